bsg_miniblade_link_relay: RTL

- Pipelined repeater inserted on a mesh link between two adjacent miniblade compute tiles, for long inter-tile wires.
- Sits directly upstream of a tile's link_i / barrier_link_i for one direction, fed by the neighbour tile's link_o / barrier_link_o.
- Re-times both channels of the link, each through a 2-entry ready/valid buffer:
  - forward (request) channel, neighbour -> tile;
  - reverse (response) channel, tile -> neighbour.
- Also re-times the single barrier bit.
- No combinational path from any ready input to any ready output.

---
 rtl/bsg_miniblade_pkg.sv | 13 +
 rtl/bsg_miniblade_link_relay_fifo.sv | 71 +++++++
 rtl/bsg_miniblade_link_relay.sv | 88 ++++++++
 3 files changed

// File: rtl/bsg_miniblade_pkg.sv
// Shared constants for the miniblade link relay.
package bsg_miniblade_pkg;

  // Only a two-entry skid buffer per channel is supported.
  localparam int miniblade_relay_els_gp = 2;

  // Width of the optional per-channel stall counters.
  localparam int miniblade_perf_cnt_width_gp = 32;

  // Buffer occupancy, 0..miniblade_relay_els_gp.
  typedef logic [1:0] relay_count_t;

endpackage

// File: rtl/bsg_miniblade_link_relay_fifo.sv
// Two-entry ready/valid buffer for one link channel.
// Optional stall counter when BSG_MINIBLADE_LINK_RELAY_PERF_EN is defined.
module bsg_miniblade_link_relay_fifo
  import bsg_miniblade_pkg::*;
#(
  parameter int width_p = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reset_done,
  input  logic               enq_v,
  input  logic [width_p-1:0] enq_data,
  output logic               enq_ready,
  output logic               deq_v,
  output logic [width_p-1:0] deq_data,
  input  logic               deq_ready
`ifdef BSG_MINIBLADE_LINK_RELAY_PERF_EN
  ,
  output logic [miniblade_perf_cnt_width_gp-1:0] stall_cnt
`endif
);

  relay_count_t       count;
  logic               head;
  logic               tail;
  logic [width_p-1:0] mem [miniblade_relay_els_gp];
  logic               enq;
  logic               deq;

  // ready depends only on registered state, so there is no ready-to-ready path.
  assign enq_ready = (count != relay_count_t'(miniblade_relay_els_gp)) & reset_done;
  assign deq_v     = (count != '0);
  assign deq_data  = mem[head];
  assign enq       = enq_v & enq_ready;
  assign deq       = deq_v & deq_ready;

  // Occupancy and pointer update; pointers wrap modulo 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      if (enq & ~deq)      count <= count + relay_count_t'(1);
      else if (deq & ~enq) count <= count - relay_count_t'(1);
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_data;
  end

`ifdef BSG_MINIBLADE_LINK_RELAY_PERF_EN
  logic [miniblade_perf_cnt_width_gp-1:0] stall_r;

  // Saturating count of cycles where output is offered but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= '0;
    end else if (deq_v & ~deq_ready & (stall_r != '1)) begin
      stall_r <= stall_r + miniblade_perf_cnt_width_gp'(1);
    end
  end

  assign stall_cnt = stall_r;
`endif

endmodule

// File: rtl/bsg_miniblade_link_relay.sv
// Pipelined repeater for one direction of a miniblade inter-tile mesh link.
// Re-times the forward and reverse channels through 2-entry buffers and the
// barrier bit through one flop.
// Optional stall counters when BSG_MINIBLADE_LINK_RELAY_PERF_EN is defined.
module bsg_miniblade_link_relay
  import bsg_miniblade_pkg::*;
#(
  parameter int fwd_width_p = 1,
  parameter int rev_width_p = 1,
  parameter int els_p       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   fwd_v_i,
  input  logic [fwd_width_p-1:0] fwd_data_i,
  output logic                   fwd_ready_o,
  output logic                   fwd_v_o,
  output logic [fwd_width_p-1:0] fwd_data_o,
  input  logic                   fwd_ready_i,
  input  logic                   rev_v_i,
  input  logic [rev_width_p-1:0] rev_data_i,
  output logic                   rev_ready_o,
  output logic                   rev_v_o,
  output logic [rev_width_p-1:0] rev_data_o,
  input  logic                   rev_ready_i,
  input  logic                   barrier_i,
  output logic                   barrier_o
`ifdef BSG_MINIBLADE_LINK_RELAY_PERF_EN
  ,
  output logic [miniblade_perf_cnt_width_gp-1:0] fwd_stall_cnt_o,
  output logic [miniblade_perf_cnt_width_gp-1:0] rev_stall_cnt_o
`endif
);

  if (els_p != miniblade_relay_els_gp) begin : g_bad_els
    $error("bsg_miniblade_link_relay: els_p must be 2");
  end

  logic reset_done_r;
  logic barrier_r;

  // Hold off accepting for one cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) reset_done_r <= 1'b0;
    else            reset_done_r <= 1'b1;
  end

  // Barrier bit re-timed by one cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) barrier_r <= 1'b0;
    else            barrier_r <= barrier_i;
  end

  assign barrier_o = barrier_r;

  bsg_miniblade_link_relay_fifo #(.width_p(fwd_width_p)) fwd_fifo (
    .clk        (clk_i),
    .rst_n      (reset_n_i),
    .reset_done (reset_done_r),
    .enq_v      (fwd_v_i),
    .enq_data   (fwd_data_i),
    .enq_ready  (fwd_ready_o),
    .deq_v      (fwd_v_o),
    .deq_data   (fwd_data_o),
    .deq_ready  (fwd_ready_i)
`ifdef BSG_MINIBLADE_LINK_RELAY_PERF_EN
    ,
    .stall_cnt  (fwd_stall_cnt_o)
`endif
  );

  bsg_miniblade_link_relay_fifo #(.width_p(rev_width_p)) rev_fifo (
    .clk        (clk_i),
    .rst_n      (reset_n_i),
    .reset_done (reset_done_r),
    .enq_v      (rev_v_i),
    .enq_data   (rev_data_i),
    .enq_ready  (rev_ready_o),
    .deq_v      (rev_v_o),
    .deq_data   (rev_data_o),
    .deq_ready  (rev_ready_i)
`ifdef BSG_MINIBLADE_LINK_RELAY_PERF_EN
    ,
    .stall_cnt  (rev_stall_cnt_o)
`endif
  );

endmodule
